qarctan_div_ctrl: RTL

//  FM demodulator angle stage placed directly upstream of the sequential divider (div).

---
 rtl/qarctan_div_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/qarctan_div_ctrl.sv
// qarctan_div_ctrl: FM demodulator angle stage in front of the sequential divider.
// Accepts one I/Q product sample, forms the quantized-arctan ratio num/den,
// issues one request to the divider, then turns the quotient into a phase angle.
// Only one sample is in flight; the input is stalled while busy.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | in_ready high, waiting for a sample
// CALC     | form num/den from registered x/y, load divider operands
// DIV_REQ  | div_valid_in pulses for this single cycle
// DIV_WAIT | operands held, waiting for div_valid_out
// ANGLE    | convert the captured quotient into a phase angle
// OUT      | out_valid high, angle_out held until out_ready
module qarctan_div_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int QUANT_BITS     = 10,
  parameter int QUAD1          = 804,
  parameter int QUAD3          = 2412,
  parameter int DIV_DIVIDEND_W = 64,
  parameter int DIV_DIVISOR_W  = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic        [DATA_WIDTH-1:0]     real_in,
  input  logic        [DATA_WIDTH-1:0]     imag_in,
  output logic                             div_valid_in,
  output logic        [DIV_DIVIDEND_W-1:0] div_dividend,
  output logic        [DIV_DIVISOR_W-1:0]  div_divisor,
  input  logic        [DIV_DIVIDEND_W-1:0] div_quotient,
  input  logic                             div_valid_out,
  input  logic                             div_overflow,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic        [DATA_WIDTH-1:0]     angle_out,
  output logic                             err_overflow
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CALC     = 3'd1,
    DIV_REQ  = 3'd2,
    DIV_WAIT = 3'd3,
    ANGLE    = 3'd4,
    OUT      = 3'd5
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0]   QUAD1_D = DATA_WIDTH'(QUAD1);
  localparam logic signed [DATA_WIDTH-1:0]   QUAD3_D = DATA_WIDTH'(QUAD3);
  localparam logic signed [2*DATA_WIDTH-1:0] QUAD1_P = (2*DATA_WIDTH)'(QUAD1);
  localparam logic        [DATA_WIDTH:0]     ONE_E   = {{DATA_WIDTH{1'b0}}, 1'b1};

  state_t                         state;
  logic signed [DATA_WIDTH-1:0]   x_q;
  logic signed [DATA_WIDTH-1:0]   y_q;
  logic signed [DATA_WIDTH-1:0]   r_q;
  logic                           x_neg;
  logic                           y_neg;

  logic signed [DATA_WIDTH:0]     x_ext;
  logic signed [DATA_WIDTH:0]     y_ext;
  logic signed [DATA_WIDTH:0]     abs_y;
  logic signed [DATA_WIDTH:0]     num;
  logic signed [DATA_WIDTH:0]     den;
  logic        [DIV_DIVIDEND_W-1:0] dividend_w;
  logic        [DIV_DIVISOR_W-1:0]  divisor_w;

  logic signed [2*DATA_WIDTH-1:0] r_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]   base;
  logic signed [DATA_WIDTH-1:0]   a_pos;
  logic signed [DATA_WIDTH-1:0]   angle_w;

  // Quotient bits above DATA_WIDTH and den's top bit are zero-valued by the
  // input range (|x|,|y| < 2^30) and intentionally dropped.
  logic unused_quot_hi;
  logic unused_den_hi;
  assign unused_quot_hi = ^div_quotient[DIV_DIVIDEND_W-1:DATA_WIDTH];
  assign unused_den_hi  = ^den[DATA_WIDTH:DIV_DIVISOR_W];

  // Ratio operands: one extra bit of headroom so |x|+|y|+1 cannot wrap.
  always_comb begin
    x_ext = {x_q[DATA_WIDTH-1], x_q};
    y_ext = {y_q[DATA_WIDTH-1], y_q};
    abs_y = (y_q[DATA_WIDTH-1] ? -y_ext : y_ext) + ONE_E;
    if (!x_q[DATA_WIDTH-1]) begin
      num = x_ext - abs_y;
      den = x_ext + abs_y;
    end else begin
      num = x_ext + abs_y;
      den = abs_y - x_ext;
    end
    dividend_w = {{(DIV_DIVIDEND_W-DATA_WIDTH-1){num[DATA_WIDTH]}}, num} <<< QUANT_BITS;
    divisor_w  = den[DIV_DIVISOR_W-1:0];
  end

  // Angle from quotient: base - floor(QUAD1*r / QUANT), mirrored for y<0.
  always_comb begin
    r_ext   = {{DATA_WIDTH{r_q[DATA_WIDTH-1]}}, r_q};
    prod    = r_ext * QUAD1_P;
    base    = x_neg ? QUAD3_D : QUAD1_D;
    a_pos   = base - DATA_WIDTH'(prod >>> QUANT_BITS);
    angle_w = y_neg ? -a_pos : a_pos;
  end

  // Control FSM with all handshake and datapath outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      div_valid_in <= 1'b0;
      err_overflow <= 1'b0;
      angle_out    <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      x_q          <= '0;
      y_q          <= '0;
      r_q          <= '0;
      x_neg        <= 1'b0;
      y_neg        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q      <= real_in;
            y_q      <= imag_in;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          div_dividend <= dividend_w;
          div_divisor  <= divisor_w;
          x_neg        <= x_q[DATA_WIDTH-1];
          y_neg        <= y_q[DATA_WIDTH-1];
          div_valid_in <= 1'b1;
          state        <= DIV_REQ;
        end
        DIV_REQ: begin
          div_valid_in <= 1'b0;
          state        <= DIV_WAIT;
        end
        DIV_WAIT: begin
          if (div_valid_out) begin
            if (div_overflow) begin
              r_q          <= '0;
              err_overflow <= 1'b1;
            end else begin
              r_q <= div_quotient[DATA_WIDTH-1:0];
            end
            state <= ANGLE;
          end
        end
        ANGLE: begin
          angle_out <= angle_w;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          in_ready     <= 1'b1;
          out_valid    <= 1'b0;
          div_valid_in <= 1'b0;
        end
      endcase
    end
  end

endmodule
